key_digit_entry: RTL and testbench

KEY_DIGIT_ENTRY -- requirements
Module: key_digit_entry

---
 rtl/key_entry_pkg.sv | 22 ++
 rtl/bcd2bin.sv | 10 +
 rtl/key_digit_entry.sv | 187 ++++++++++++++++++
 tb/tb_key_digit_entry.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/key_entry_pkg.sv
// Shared types and key indices for the two-digit keypad entry block.
package key_entry_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } entry_state_t;

    typedef enum logic [2:0] {
        EV_NONE  = 3'd0,
        EV_DIGIT = 3'd1,
        EV_BS    = 3'd2,
        EV_CLR   = 3'd3,
        EV_ENT   = 3'd4
    } key_event_t;

    localparam int unsigned KEY_BS  = 10;
    localparam int unsigned KEY_CLR = 11;
    localparam int unsigned KEY_ENT = 12;

endpackage

// File: rtl/bcd2bin.sv
// Two-digit BCD to binary: tens*10 + units, built from shifts (8t + 2t + u).
module bcd2bin (
    input  logic [3:0] tens,
    input  logic [3:0] units,
    output logic [6:0] bin
);

    assign bin = {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, units};

endmodule

// File: rtl/key_digit_entry.sv
// Two-digit keypad entry with backspace/clear/enter and idle auto-clear.
// Define KEY_DIGIT_ENTRY_LOCK_EN to reject a third digit instead of shifting.
module key_digit_entry
    import key_entry_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 60_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] key_pulse,
    output logic [7:0]  seg_data,
    output logic [1:0]  digit_cnt,
    output logic [6:0]  value_bin,
    output logic        value_valid,
    output logic        full_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] IDLE_MAX = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
    localparam logic TIMEOUT_ON = (TIMEOUT_CYC != 0);

    entry_state_t     state_r, state_s;
    key_event_t       ev_s;
    logic [3:0]       key_idx_s;
    logic [3:0]       tens_r, tens_s, units_r, units_s;
    logic [CNT_W-1:0] idle_r, idle_s;
    logic [6:0]       value_r, conv_s;
    logic             valid_r, load_s, timeout_s;
`ifdef KEY_DIGIT_ENTRY_LOCK_EN
    logic             full_err_r, full_err_s;
`endif

    bcd2bin u_bcd2bin (
        .tens  (tens_r),
        .units (units_r),
        .bin   (conv_s)
    );

    // Key decode: multi-key cycles and keys 13-15 produce no event
    always_comb begin
        key_idx_s = 4'd0;
        ev_s      = EV_NONE;
        for (int i = 0; i < 16; i++) begin
            key_idx_s = key_idx_s | (key_pulse[i] ? 4'(i) : 4'd0);
        end
        if ($onehot(key_pulse)) begin
            if (key_idx_s <= 4'd9)                 ev_s = EV_DIGIT;
            else if (key_idx_s == 4'(KEY_BS))      ev_s = EV_BS;
            else if (key_idx_s == 4'(KEY_CLR))     ev_s = EV_CLR;
            else if (key_idx_s == 4'(KEY_ENT))     ev_s = EV_ENT;
            else                                   ev_s = EV_NONE;
        end else begin
            ev_s = EV_NONE;
        end
    end

    // Entry FSM next state; a key event always wins over timeout expiry
    always_comb begin
        state_s   = state_r;
        tens_s    = tens_r;
        units_s   = units_r;
        load_s    = 1'b0;
`ifdef KEY_DIGIT_ENTRY_LOCK_EN
        full_err_s = 1'b0;
`endif
        timeout_s = TIMEOUT_ON && (idle_r == IDLE_MAX) && (state_r != EMPTY);
        case (ev_s)
            EV_DIGIT: begin
                case (state_r)
                    EMPTY: begin
                        state_s = ONE;
                        tens_s  = 4'd0;
                        units_s = key_idx_s;
                    end
                    ONE: begin
                        state_s = TWO;
                        tens_s  = units_r;
                        units_s = key_idx_s;
                    end
                    TWO: begin
`ifdef KEY_DIGIT_ENTRY_LOCK_EN
                        full_err_s = 1'b1;
`else
                        tens_s  = units_r;
                        units_s = key_idx_s;
`endif
                    end
                    default: begin
                        state_s = EMPTY;
                        tens_s  = 4'd0;
                        units_s = 4'd0;
                    end
                endcase
            end
            EV_BS: begin
                case (state_r)
                    TWO: begin
                        state_s = ONE;
                        tens_s  = 4'd0;
                        units_s = tens_r;
                    end
                    default: begin
                        state_s = EMPTY;
                        tens_s  = 4'd0;
                        units_s = 4'd0;
                    end
                endcase
            end
            EV_CLR: begin
                state_s = EMPTY;
                tens_s  = 4'd0;
                units_s = 4'd0;
            end
            EV_ENT: begin
                if (state_r != EMPTY) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
                state_s = EMPTY;
                tens_s  = 4'd0;
                units_s = 4'd0;
            end
            default: begin
                if (timeout_s) begin
                    state_s = EMPTY;
                    tens_s  = 4'd0;
                    units_s = 4'd0;
                end else begin
                    state_s = state_r;
                end
            end
        endcase
    end

    // Idle counter: cleared by any decoded key, saturates at the expiry value
    always_comb begin
        if (ev_s != EV_NONE) begin
            idle_s = '0;
        end else if (idle_r != IDLE_MAX) begin
            idle_s = idle_r + CNT_W'(1);
        end else begin
            idle_s = idle_r;
        end
    end

    // State, digit and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= EMPTY;
            tens_r  <= 4'd0;
            units_r <= 4'd0;
            idle_r  <= '0;
            value_r <= 7'd0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            tens_r  <= tens_s;
            units_r <= units_s;
            idle_r  <= idle_s;
            valid_r <= load_s;
            if (load_s) begin
                value_r <= conv_s;
            end
        end
    end

`ifdef KEY_DIGIT_ENTRY_LOCK_EN
    // Rejected-digit pulse register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_err_r <= 1'b0;
        end else begin
            full_err_r <= full_err_s;
        end
    end
    assign full_err = full_err_r;
`else
    assign full_err = 1'b0;
`endif

    assign seg_data    = {tens_r, units_r};
    assign digit_cnt   = state_r;
    assign value_bin   = value_r;
    assign value_valid = valid_r;

endmodule

// File: tb/tb_key_digit_entry.sv
// Directed bench for key_digit_entry; committed values and error pulses go
// through a scoreboard that a negedge monitor drains.
module tb_key_digit_entry;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] key_pulse = 16'h0000;
    logic [7:0]  seg_data;
    logic [1:0]  digit_cnt;
    logic [6:0]  value_bin;
    logic        value_valid;
    logic        full_err;

    int checks = 0;
    int errors = 0;
    logic [6:0] val_q[$];
    bit         err_q[$];

    key_digit_entry #(.TIMEOUT_CYC(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_pulse   (key_pulse),
        .seg_data    (seg_data),
        .digit_cnt   (digit_cnt),
        .value_bin   (value_bin),
        .value_valid (value_valid),
        .full_err    (full_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic press(input int k);
        @(negedge clk);
        key_pulse = 16'h0001 << k;
        @(negedge clk);
        key_pulse = 16'h0000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor: every value_valid / full_err pulse must be expected
    always @(negedge clk) begin
        if (rst_n) begin
            if (value_valid) begin
                checks++;
                if (val_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid actual=1 expected=0 value_bin=%0d", value_bin);
                end else begin
                    logic [6:0] exp_v;
                    exp_v = val_q.pop_front();
                    if (value_bin !== exp_v) begin
                        errors++;
                        $display("FAIL value_bin actual=%0d expected=%0d", value_bin, exp_v);
                    end
                end
            end
            if (full_err) begin
                checks++;
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_full_err actual=1 expected=0");
                end else begin
                    void'(err_q.pop_front());
                end
            end
        end
    end

    initial begin
        idle(3);
        check("rst_seg", 16'(seg_data), 16'h00);
        check("rst_cnt", 16'(digit_cnt), 16'd0);
        check("rst_val", 16'(value_bin), 16'd0);
        check("rst_vvalid", 16'(value_valid), 16'd0);
        check("rst_ferr", 16'(full_err), 16'd0);
        rst_n = 1'b1;

        // 4, 7, ENTER -> 47
        press(4);  check("d4_seg", 16'(seg_data), 16'h04); check("d4_cnt", 16'(digit_cnt), 16'd1);
        press(7);  check("d47_seg", 16'(seg_data), 16'h47); check("d47_cnt", 16'(digit_cnt), 16'd2);
        val_q.push_back(7'd47);
        press(12); check("ent_seg", 16'(seg_data), 16'h00); check("ent_cnt", 16'(digit_cnt), 16'd0);
        check("ent_vvalid", 16'(value_valid), 16'd1);
        idle(1);   check("vvalid_drop", 16'(value_valid), 16'd0);

        // 1, 2, 3: shift or lock
        press(1); press(2);
`ifdef KEY_DIGIT_ENTRY_LOCK_EN
        err_q.push_back(1'b1);
        press(3);  check("lock_seg", 16'(seg_data), 16'h12);
`else
        press(3);  check("shift_seg", 16'(seg_data), 16'h23);
`endif
        check("d3_cnt", 16'(digit_cnt), 16'd2);
        press(11); check("clr_seg", 16'(seg_data), 16'h00); check("clr_cnt", 16'(digit_cnt), 16'd0);
        check("clr_keeps_val", 16'(value_bin), 16'd47);

        // 9, 5, BS, BS, ENTER in EMPTY
        press(9); press(5); check("d95_seg", 16'(seg_data), 16'h95);
        press(10); check("bs1_seg", 16'(seg_data), 16'h09); check("bs1_cnt", 16'(digit_cnt), 16'd1);
        press(10); check("bs2_seg", 16'(seg_data), 16'h00); check("bs2_cnt", 16'(digit_cnt), 16'd0);
        press(10); check("bs_empty_seg", 16'(seg_data), 16'h00);
        press(12); idle(3);
        check("ent_empty_val", 16'(value_bin), 16'd47);

        // multi-key and ignored keys
        press(5);
        @(negedge clk); key_pulse = 16'h0003; @(negedge clk); key_pulse = 16'h0000;
        check("multi_seg", 16'(seg_data), 16'h05); check("multi_cnt", 16'(digit_cnt), 16'd1);
        press(13); check("key13_seg", 16'(seg_data), 16'h05);
        press(11);

        // timeout after 16 idle cycles
        press(6);
        idle(15);  check("to_pre_seg", 16'(seg_data), 16'h06);
        idle(1);   check("to_seg", 16'(seg_data), 16'h00); check("to_cnt", 16'(digit_cnt), 16'd0);
        check("to_keeps_val", 16'(value_bin), 16'd47);

        // key in expiry cycle wins, then commit 67
        press(6);
        idle(14);
        press(7);  check("prio_seg", 16'(seg_data), 16'h67);
        idle(1);   check("prio_hold_seg", 16'(seg_data), 16'h67);
        val_q.push_back(7'd67);
        press(12);
        press(9); press(9); val_q.push_back(7'd99); press(12);
        press(0); val_q.push_back(7'd0); press(12);
        idle(1);   check("val_zero", 16'(value_bin), 16'd0);

        // reset mid-entry, key during reset discarded
        press(8);  check("d8_seg", 16'(seg_data), 16'h08);
        #2 rst_n = 1'b0;
        #1;
        check("arst_seg", 16'(seg_data), 16'h00); check("arst_cnt", 16'(digit_cnt), 16'd0);
        check("arst_val", 16'(value_bin), 16'd0); check("arst_vvalid", 16'(value_valid), 16'd0);
        key_pulse = 16'h0020;
        @(negedge clk); key_pulse = 16'h0000; rst_n = 1'b1;
        check("rst_key_discard", 16'(seg_data), 16'h00);
        press(3);  check("post_rst_seg", 16'(seg_data), 16'h03); check("post_rst_cnt", 16'(digit_cnt), 16'd1);

        idle(4);
        check("val_q_empty", 16'(val_q.size()), 16'd0);
        check("err_q_empty", 16'(err_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
